// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern generator: pattern mode
// encodings and the colour-bar ordering used by the BARS pattern.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_GRID    = 2'd3
  } mode_e;

  localparam int NUM_BARS = 8;

  // Bar colours {r,g,b} left to right: white, yellow, cyan, green,
  // magenta, red, blue, black. Equivalent to {~k[1], ~k[2], ~k[0]}.
  localparam logic [2:0] BAR_RGB [NUM_BARS] = '{
    3'b111, 3'b110, 3'b011, 3'b010,
    3'b101, 3'b100, 3'b001, 3'b000
  };

  // One bit per channel for bar k; the caller replicates to channel depth.
  function automatic logic [2:0] bar_rgb(input logic [2:0] k);
    return BAR_RGB[k];
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pixel bus between the timing generator and the pattern generator.
// master drives position/config and receives colour; slave is the generator.
interface vga_pattern_gen_if #(
  parameter int X_W     = 10,
  parameter int Y_W     = 11,
  parameter int COLOR_W = 1
);
  logic                   pxl_en;
  logic [X_W-1:0]         x;
  logic [Y_W-1:0]         y;
  logic                   frame_start;
  logic [1:0]             mode_i;
  logic [3*COLOR_W-1:0]   fg_i;
  logic [3*COLOR_W-1:0]   bg_i;
  logic [COLOR_W-1:0]     r;
  logic [COLOR_W-1:0]     g;
  logic [COLOR_W-1:0]     b;
  logic                   de_out;

  modport master (
    output pxl_en, x, y, frame_start, mode_i, fg_i, bg_i,
    input  r, g, b, de_out
  );

  modport slave (
    input  pxl_en, x, y, frame_start, mode_i, fg_i, bg_i,
    output r, g, b, de_out
  );
endinterface

// File: rtl/vga_bar_index.sv
// Maps a column to its colour-bar index (0..7) using constant
// threshold compares against the active width; no divider.
module vga_bar_index #(
  parameter int X_W      = 10,
  parameter int H_ACTIVE = 640
) (
  input  logic [X_W-1:0] x,
  output logic [2:0]     idx
);

  // Largest k whose bar start (k*H_ACTIVE/8) is at or left of x.
  always_comb begin
    idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (x >= X_W'((k * H_ACTIVE) / 8)) idx = 3'(k);
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Pixel colour generator: solid / colour bars / checkerboard / grid,
// with frame-synchronous config shadows and two-cycle output latency.
// Optional feature macro VGA_PATTERN_SCROLL_EN: checkerboard scrolls
// left by SCROLL_STEP pixels per frame.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int X_W         = 10,
  parameter int Y_W         = 11,
  parameter int COLOR_W     = 1,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int CELL_LOG2   = 5,
  parameter int SCROLL_STEP = 1
) (
  input logic              clk,
  input logic              rst_n,
  vga_pattern_gen_if.slave bus
);

  localparam int CW3 = 3 * COLOR_W;
  localparam logic [CW3-1:0] RED_FULL = {{COLOR_W{1'b1}}, {(2*COLOR_W){1'b0}}};

  mode_e          mode_q;
  logic [CW3-1:0] fg_q;
  logic [CW3-1:0] bg_q;
  logic [X_W-1:0] scroll;

  logic [2:0]     bar_idx;
  logic           blank;
  logic [X_W-1:0] x_scr;
  logic           chk_sel;
  logic           grid_sel;
  logic           pat_sel;

  logic           s1_blank;
  logic           s1_de;
  mode_e          s1_mode;
  logic [2:0]     s1_bar;
  logic           s1_sel;
  logic [CW3-1:0] s1_fg;
  logic [CW3-1:0] s1_bg;

  logic [2:0]     bar_bits;
  logic [CW3-1:0] colour;

  // Shadow config registers only take new values on the frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_SOLID;
      fg_q   <= RED_FULL;
      bg_q   <= '0;
    end else if (bus.frame_start) begin
      mode_q <= mode_e'(bus.mode_i);
      fg_q   <= bus.fg_i;
      bg_q   <= bus.bg_i;
    end
  end

`ifdef VGA_PATTERN_SCROLL_EN
  // Scroll offset advances once per frame and wraps at 2^X_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                scroll <= '0;
    else if (bus.frame_start)  scroll <= scroll + X_W'(SCROLL_STEP);
  end
`else
  assign scroll = '0;
`endif

  vga_bar_index #(
    .X_W      (X_W),
    .H_ACTIVE (H_ACTIVE)
  ) u_bar_index (
    .x   (bus.x),
    .idx (bar_idx)
  );

  // Stage-1 decode: range blanking and checker/grid foreground select.
  always_comb begin
    blank    = !bus.pxl_en || (bus.x >= X_W'(H_ACTIVE)) || (bus.y >= Y_W'(V_ACTIVE));
    x_scr    = bus.x + scroll;
    chk_sel  = x_scr[CELL_LOG2] ^ bus.y[CELL_LOG2];
    grid_sel = (bus.x[CELL_LOG2-1:0] == '0) || (bus.y[CELL_LOG2-1:0] == '0) ||
               (bus.x == X_W'(H_ACTIVE - 1)) || (bus.y == Y_W'(V_ACTIVE - 1));
    pat_sel  = (mode_q == MODE_GRID) ? grid_sel : chk_sel;
  end

  // Stage 1 snapshots the shadows so a same-cycle frame pulse cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_blank <= 1'b0;
      s1_de    <= 1'b0;
      s1_mode  <= MODE_SOLID;
      s1_bar   <= '0;
      s1_sel   <= 1'b0;
      s1_fg    <= '0;
      s1_bg    <= '0;
    end else begin
      s1_blank <= blank;
      s1_de    <= bus.pxl_en;
      s1_mode  <= mode_q;
      s1_bar   <= bar_idx;
      s1_sel   <= pat_sel;
      s1_fg    <= fg_q;
      s1_bg    <= bg_q;
    end
  end

  // Stage-2 colour selection from the registered decode.
  always_comb begin
    bar_bits = bar_rgb(s1_bar);
    case (s1_mode)
      MODE_SOLID: colour = s1_fg;
      MODE_BARS:  colour = {{COLOR_W{bar_bits[2]}}, {COLOR_W{bar_bits[1]}},
                            {COLOR_W{bar_bits[0]}}};
      default:    colour = s1_sel ? s1_fg : s1_bg;
    endcase
    if (s1_blank) colour = '0;
  end

  // Output registers: colour channels and the aligned data-enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.r      <= '0;
      bus.g      <= '0;
      bus.b      <= '0;
      bus.de_out <= 1'b0;
    end else begin
      bus.r      <= colour[CW3-1 -: COLOR_W];
      bus.g      <= colour[2*COLOR_W-1 -: COLOR_W];
      bus.b      <= colour[COLOR_W-1:0];
      bus.de_out <= s1_de;
    end
  end

endmodule
